// File: rtl/conv_pkg.sv
// conv_pkg: shared window geometry constants and tap offset helper.
package conv_pkg;
  localparam int KSIZE = 5;
  localparam int NTAPS = KSIZE * KSIZE;
  function automatic int win_idx(int r, int c, int bw);
    return (r * KSIZE + c) * bw;
  endfunction
endpackage

// File: rtl/conv_window5x5_if.sv
// conv_window5x5_if: pixel/tap inputs and window outputs of the window generator.
interface conv_window5x5_if #(parameter int BIT_WIDTH = 8, parameter int CW = 5);
  logic en;
  logic sof;
  logic [BIT_WIDTH-1:0] pix_in;
  logic [BIT_WIDTH-1:0] rb_row0;
  logic [BIT_WIDTH-1:0] rb_row1;
  logic [BIT_WIDTH-1:0] rb_row2;
  logic [BIT_WIDTH-1:0] rb_row3;
  logic [25*BIT_WIDTH-1:0] win;
  logic win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic frame_done;
  modport master(output en, sof, pix_in, rb_row0, rb_row1, rb_row2, rb_row3,
                 input win, win_valid, win_row, win_col, frame_done);
  modport slave(input en, sof, pix_in, rb_row0, rb_row1, rb_row2, rb_row3,
                output win, win_valid, win_row, win_col, frame_done);
endinterface

// File: rtl/conv_window5x5_pix_pos_counter.sv
// pix_pos_counter: frame position tracking with sof resync, window validity and frame end.
module pix_pos_counter import conv_pkg::*; #(
  parameter int COLS = 28,
  parameter int ROWS = 28,
  parameter int CW = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sof,
  output logic valid,
  output logic frame_done,
  output logic [CW-1:0] win_row,
  output logic [CW-1:0] win_col
);
  logic [CW-1:0] col, row, cc, cr;
  logic last_c, last_r, fire;
  // sof relabels the pixel being accepted as (0,0)
  always_comb begin
    cc = sof ? '0 : col;
    cr = sof ? '0 : row;
    last_c = cc == CW'(COLS - 1);
    last_r = cr == CW'(ROWS - 1);
    fire = en && cr >= CW'(KSIZE - 1) && cc >= CW'(KSIZE - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
      valid <= 1'b0;
      frame_done <= 1'b0;
      win_row <= '0;
      win_col <= '0;
    end else begin
      valid <= fire;
      frame_done <= en && last_c && last_r;
      if (en) begin
        col <= last_c ? '0 : cc + CW'(1);
        row <= last_c ? (last_r ? '0 : cr + CW'(1)) : cr;
      end
      if (fire) begin
        win_row <= cr - CW'(KSIZE - 1);
        win_col <= cc - CW'(KSIZE - 1);
      end
    end
endmodule

// File: rtl/conv_window5x5.sv
// conv_window5x5: 5x5 sliding window built from the live pixel and four line-buffer taps.
module conv_window5x5 import conv_pkg::*; #(
  parameter int COLS = 28,
  parameter int ROWS = 28,
  parameter int BIT_WIDTH = 8,
  parameter int CW = 5
) (
  input logic clk,
  input logic rst,
  conv_window5x5_if.slave s
);
  logic [NTAPS*BIT_WIDTH-1:0] win_r;
  logic [BIT_WIDTH-1:0] vcol [KSIZE];
  // oldest row (4 rows back) lands at the top of the new column
  always_comb begin
    vcol[0] = s.rb_row3;
    vcol[1] = s.rb_row2;
    vcol[2] = s.rb_row1;
    vcol[3] = s.rb_row0;
    vcol[4] = s.pix_in;
  end
  always_ff @(posedge clk)
    if (rst) win_r <= '0;
    else if (s.en)
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++)
          win_r[win_idx(r, c, BIT_WIDTH) +: BIT_WIDTH] <= win_r[win_idx(r, c + 1, BIT_WIDTH) +: BIT_WIDTH];
        win_r[win_idx(r, KSIZE - 1, BIT_WIDTH) +: BIT_WIDTH] <= vcol[r];
      end
  assign s.win = win_r;
  pix_pos_counter #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) u_pos (
    .clk(clk),
    .rst(rst),
    .en(s.en),
    .sof(s.sof),
    .valid(s.win_valid),
    .frame_done(s.frame_done),
    .win_row(s.win_row),
    .win_col(s.win_col)
  );
endmodule
